// File: rtl/ff_d_ureg_pkg.sv
// Shared mode encodings and the next-state function for the universal register.
// The function works on a MAX_W-bit container so any WIDTH up to MAX_W can reuse it.
package ff_d_ureg_pkg;

    localparam int MAX_W = 64;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_UP   = 3'b100;
    localparam logic [2:0] MODE_DOWN = 3'b101;
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_ROR  = 3'b111;

    // Bits at and above w are masked off, so +1/-1 wrap modulo 2^w silently.
    function automatic logic [MAX_W-1:0] ureg_next(
        input logic [MAX_W-1:0] q,
        input logic [2:0]       mode,
        input logic [MAX_W-1:0] d,
        input logic             sin_l,
        input logic             sin_r,
        input int               w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] top_bit;
        logic [MAX_W-1:0] r;
        mask    = (MAX_W'(1) << w) - MAX_W'(1);
        top_bit = MAX_W'(1) << (w - 1);
        case (mode)
            MODE_HOLD: r = q;
            MODE_LOAD: r = d;
            MODE_SHL:  r = (q << 1) | MAX_W'(sin_r);
            MODE_SHR:  r = (q >> 1) | (sin_l ? top_bit : '0);
            MODE_UP:   r = q + MAX_W'(1);
            MODE_DOWN: r = q - MAX_W'(1);
            MODE_ROL:  r = (q << 1) | ((q >> (w - 1)) & MAX_W'(1));
            MODE_ROR:  r = (q >> 1) | ((q[0] == 1'b1) ? top_bit : '0);
            default:   r = 'x;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/ff_d_ureg_cell.sv
// Single state bit: async clear, synchronous preset to PRESET_BIT, enable-gated next value.
// Updates on the falling clock edge when NEG_EDGE=1, otherwise on the rising edge.
module ureg_cell #(
    parameter logic PRESET_BIT = 1'b1,
    parameter bit   NEG_EDGE   = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic pr,
    input  logic en,
    input  logic nxt,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (pr) begin
            q_d = PRESET_BIT;
        end else if (en) begin
            q_d = nxt;
        end
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk or posedge clr) begin
            if (clr) begin
                q_q <= 1'b0;
            end else begin
                q_q <= q_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                q_q <= 1'b0;
            end else begin
                q_q <= q_d;
            end
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ff_d_ureg.sv
// WIDTH-bit universal register: hold/load/shift/rotate/up-down count with preset and async clear.
// One active edge from inputs to q; tc is combinational from q/mode/en; ovf sticks until clr or pr.
module ff_d_ureg
    import ff_d_ureg_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    parameter bit               NEG_EDGE   = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [MAX_W-1:0] q_ext;
    logic [MAX_W-1:0] d_ext;
    logic [MAX_W-1:0] nxt_ext;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q_int;
    logic             tc_int;
    logic             ovf_int;

    always_comb begin
        q_ext   = MAX_W'(q_int);
        d_ext   = MAX_W'(d);
        nxt_ext = ureg_next(q_ext, mode, d_ext, sin_l, sin_r, WIDTH);
        nxt     = nxt_ext[WIDTH-1:0];
    end

    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^nxt_ext[MAX_W-1:WIDTH];
    end

    always_comb begin
        tc_int = en & (((mode == MODE_UP)   & (q_int == {WIDTH{1'b1}})) |
                       ((mode == MODE_DOWN) & (q_int == '0)));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ureg_cell #(
            .PRESET_BIT (PRESET_VAL[i]),
            .NEG_EDGE   (NEG_EDGE)
        ) u_cell (
            .clk (clk),
            .clr (clr),
            .pr  (pr),
            .en  (en),
            .nxt (nxt[i]),
            .q   (q_int[i])
        );
    end

    // The wrap flag is just another cell: preset clears it, a wrap edge loads a 1.
    ureg_cell #(
        .PRESET_BIT (1'b0),
        .NEG_EDGE   (NEG_EDGE)
    ) u_ovf (
        .clk (clk),
        .clr (clr),
        .pr  (pr),
        .en  (tc_int),
        .nxt (1'b1),
        .q   (ovf_int)
    );

    assign q   = q_int;
    assign tc  = tc_int;
    assign ovf = ovf_int;

endmodule

// File: tb/tb_ff_d_ureg.sv
// Bench for ff_d_ureg: directed vector table, async-clear and edge-select sequences,
// then randomized traffic against an arithmetic reference model.
module tb_ff_d_ureg;

    logic       clk = 1'b0;
    logic       clr, pr, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q, q_r;
    logic       tc, ovf, tc_r, ovf_r;

    int n_chk = 0;
    int n_err = 0;
    int mq, movf;

    always #5 clk = ~clk;

    ff_d_ureg #(.WIDTH(8), .PRESET_VAL(8'hFF), .NEG_EDGE(1'b1)) dut (
        .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .tc(tc), .ovf(ovf));

    ff_d_ureg #(.WIDTH(8), .PRESET_VAL(8'hFF), .NEG_EDGE(1'b0)) dut_r (
        .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q_r), .tc(tc_r), .ovf(ovf_r));

    typedef struct {
        logic       pr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic [7:0] eq;
        logic       etc;
        logic       eovf;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic sl, input logic sr);
        pr = p; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    endtask

    function automatic int m_next(int cur, int m, int dd, int sl, int sr);
        case (m)
            0: return cur;
            1: return dd;
            2: return (cur * 2 + sr) % 256;
            3: return cur / 2 + sl * 128;
            4: return (cur + 1) % 256;
            5: return (cur + 255) % 256;
            6: return (cur * 2) % 256 + cur / 128;
            default: return cur / 2 + (cur % 2) * 128;
        endcase
    endfunction

    function automatic int m_tc(int cur, int m, int e);
        return (e != 0 && ((m == 4 && cur == 255) || (m == 5 && cur == 0))) ? 1 : 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // pr, en, mode, d, sl, sr, eq, etc, eovf
        tbl[0]  = '{1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[20] = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 3'd0, 8'h12, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[25] = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[27] = '{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[28] = '{1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

        clr = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        #3;
        chk("reset_q", q, 8'h00);
        chk("reset_ovf", 8'(ovf), 8'h00);
        chk("reset_tc", 8'(tc), 8'h00);
        step();
        clr = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].pr, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sl, tbl[i].sr);
            step();
            chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
            chk($sformatf("vec%0d_tc", i), 8'(tc), 8'(tbl[i].etc));
            chk($sformatf("vec%0d_ovf", i), 8'(ovf), 8'(tbl[i].eovf));
        end

        // Async clear between edges, then clr beating pr.
        drive(1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0); step();
        chk("pre_clr_q", q, 8'h5A);
        chk("pre_clr_ovf", 8'(ovf), 8'h01);
        #3;
        clr = 1'b1;
        #1;
        chk("async_clr_q", q, 8'h00);
        chk("async_clr_ovf", 8'(ovf), 8'h00);
        pr = 1'b1;
        step();
        chk("clr_over_pr_q", q, 8'h00);
        chk("clr_over_pr_ovf", 8'(ovf), 8'h00);
        clr = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        mq = 0;
        movf = 0;

        for (int it = 0; it < 400; it++) begin
            int m, dd, tpre;
            m  = ($urandom_range(1) == 0) ? int'($urandom_range(5, 4)) : int'($urandom_range(7));
            dd = ($urandom_range(1) == 0) ? int'($urandom_range(255)) :
                 ((it % 4 == 0) ? 0 : (it % 4 == 1) ? 255 : (it % 4 == 2) ? 254 : 1);
            drive(($urandom_range(15) == 0), ($urandom_range(3) != 0), 3'(m), 8'(dd),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(31) == 0) begin
                #1;
                clr = 1'b1;
                #1;
                chk("rnd_async_q", q, 8'h00);
                chk("rnd_async_ovf", 8'(ovf), 8'h00);
                clr = 1'b0;
                mq = 0;
                movf = 0;
            end
            tpre = m_tc(mq, m, int'(en));
            if (pr) begin
                mq = 255;
                movf = 0;
            end else if (en) begin
                mq = m_next(mq, m, dd, int'(sin_l), int'(sin_r));
                movf = (movf != 0 || tpre != 0) ? 1 : 0;
            end
            step();
            chk("rnd_q", q, 8'(mq));
            chk("rnd_tc", 8'(tc), 8'(m_tc(mq, m, int'(en))));
            chk("rnd_ovf", 8'(ovf), 8'(movf));
        end

        // Edge select: rising-edge instance against the falling-edge one.
        drive(1'b0, 1'b1, 3'd1, 8'h22, 1'b0, 1'b0);
        step();
        chk("edge_pre_q", q, 8'h22);
        chk("edge_pre_q_r", q_r, 8'h22);
        d = 8'h11;
        @(posedge clk);
        #1;
        chk("edge_rise_q_r", q_r, 8'h11);
        chk("edge_rise_q_neg", q, 8'h22);
        d = 8'h33;
        step();
        chk("edge_fall_q_r", q_r, 8'h11);
        chk("edge_fall_q_neg", q, 8'h33);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
